// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared lock-FSM state type and 640x480@60 mode constants
package video_timing_pkg;
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;
  localparam int VGA_H_VA = 640;
  localparam int VGA_V_VA = 480;
  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_V_TOTAL = 525;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_V_SYNC = 2;
  localparam int CW_DEF = 13;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: registers a raw sync, normalises it to active-high and flags its leading edge
// VIDEO_TIMING_AUTOPOL_EN: polarity is learned from the shorter level of each sync period
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic raw,
  output logic lead,
  output logic pol_chg
);
  logic raw_q, lvl, lvl_p, pol;
  assign lvl = raw_q ^ pol;
  assign lead = lvl & ~lvl_p;
  // reset raw_q to the inactive level so release from reset never looks like an edge
  always_ff @(posedge iClk)
    if (iRst) begin
      raw_q <= ACTIVE_LOW;
      lvl_p <= 1'b0;
    end else begin
      raw_q <= raw;
      lvl_p <= lvl;
    end
`ifdef VIDEO_TIMING_AUTOPOL_EN
  logic raw_p, primed, det;
  logic [19:0] c0, c1;
  assign det = c0 < c1;
  // a period runs raw rise to raw rise; the partial period after reset is not trusted
  always_ff @(posedge iClk)
    if (iRst) begin
      raw_p <= ACTIVE_LOW;
      primed <= 1'b0;
      c0 <= '0;
      c1 <= '0;
      pol <= ACTIVE_LOW;
      pol_chg <= 1'b0;
    end else begin
      raw_p <= raw_q;
      pol_chg <= 1'b0;
      if (raw_q & ~raw_p) begin
        c0 <= '0;
        c1 <= 20'd1;
        primed <= 1'b1;
        if (primed && det != pol) begin
          pol <= det;
          pol_chg <= 1'b1;
        end
      end else begin
        c0 <= c0 + 20'(~raw_q & ~&c0);
        c1 <= c1 + 20'(raw_q & ~&c1);
      end
    end
`else
  assign pol = ACTIVE_LOW;
  assign pol_chg = 1'b0;
`endif
endmodule

// File: rtl/video_timing_decoder.sv
// video_timing_decoder: recovers pixel position from DE/HS/VS, measures timing and reports lock
// VIDEO_TIMING_AUTOPOL_EN: sync polarity learned from the stream instead of SYNC_ACTIVE_LOW
module video_timing_decoder
  import video_timing_pkg::*;
#(
  parameter int H_VA = VGA_H_VA,
  parameter int V_VA = VGA_V_VA,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES = 2,
  parameter int CW = CW_DEF
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iDE,
  input  logic          iHS,
  input  logic          iVS,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          oPosValid,
  output logic          oSOF,
  output logic [CW-1:0] oHTotal,
  output logic [CW-1:0] oVTotal,
  output logic [CW-1:0] oHActive,
  output logic [CW-1:0] oVActive,
  output logic          oLocked,
  output logic          oErr
);
  localparam logic [CW-1:0] MAX = '1;
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + 1'b1;
  endfunction
  state_t state, state_n;
  logic [3:0] mc, mc_n;
  logic de_q, de_p, de_fall, hs_lead, vs_lead, hs_pc, vs_pc, pol_chg;
  logic line_de, seen, sof_pend, chk, match;
  logic [CW-1:0] hcnt, vcnt, x, y, h_tot_n, h_act_n, vcnt_h, y_h;
  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs (
    .iClk(iClk), .iRst(iRst), .raw(iHS), .lead(hs_lead), .pol_chg(hs_pc)
  );
  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs (
    .iClk(iClk), .iRst(iRst), .raw(iVS), .lead(vs_lead), .pol_chg(vs_pc)
  );
  assign pol_chg = hs_pc | vs_pc;
  assign de_fall = de_p & ~de_q;
  // post-HS values, so a VS edge coinciding with HS sees the updated line count
  assign h_tot_n = hs_lead ? sat_inc(hcnt) : oHTotal;
  assign h_act_n = de_fall ? x : oHActive;
  assign vcnt_h = hs_lead ? sat_inc(vcnt) : vcnt;
  assign y_h = (hs_lead && line_de) ? sat_inc(y) : y;
  assign chk = vs_lead & seen;
  assign match = (h_tot_n == CW'(H_TOTAL)) && (vcnt_h == CW'(V_TOTAL)) &&
                 (h_act_n == CW'(H_VA)) && (y_h == CW'(V_VA)) &&
                 (h_tot_n != MAX) && (vcnt_h != MAX) && (h_act_n != MAX) && (y_h != MAX);
  always_comb begin
    state_n = state;
    mc_n = mc;
    if (pol_chg || (chk && !match)) begin
      state_n = SEARCH;
      mc_n = '0;
    end else if (chk && state != LOCKED) begin
      mc_n = mc + 4'd1;
      state_n = ({1'b0, mc} + 5'd1 >= 5'(LOCK_FRAMES)) ? LOCKED : TRACK;
    end
  end
  always_ff @(posedge iClk)
    if (iRst) begin
      state <= SEARCH;
      mc <= '0;
      de_q <= 1'b0;
      de_p <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
      x <= '0;
      y <= '0;
      line_de <= 1'b0;
      seen <= 1'b0;
      sof_pend <= 1'b0;
      oX <= '0;
      oY <= '0;
      oPosValid <= 1'b0;
      oSOF <= 1'b0;
      oHTotal <= '0;
      oVTotal <= '0;
      oHActive <= '0;
      oVActive <= '0;
      oLocked <= 1'b0;
      oErr <= 1'b0;
    end else begin
      state <= state_n;
      mc <= mc_n;
      de_q <= iDE;
      de_p <= de_q;
      hcnt <= hs_lead ? '0 : sat_inc(hcnt);
      vcnt <= vs_lead ? '0 : vcnt_h;
      y <= vs_lead ? '0 : y_h;
      x <= de_fall ? '0 : de_q ? sat_inc(x) : x;
      line_de <= de_fall | (line_de & ~hs_lead);
      seen <= seen | vs_lead;
      sof_pend <= vs_lead | (sof_pend & ~de_q);
      oX <= x;
      oY <= y;
      oPosValid <= de_q;
      oSOF <= de_q & sof_pend;
      if (seen) begin
        oHTotal <= h_tot_n;
        oHActive <= h_act_n;
      end
      if (chk) begin
        oVTotal <= vcnt_h;
        oVActive <= y_h;
      end
      oLocked <= state_n == LOCKED;
      oErr <= chk & ~match & ~pol_chg & (state == LOCKED);
    end
endmodule

// File: tb/tb_video_timing_decoder.sv
// tb_video_timing_decoder: random small-mode video stream against a stream-level reference model
module tb_video_timing_decoder;
  localparam int HVA = 24, VVA = 12, HT = 40, VT = 20, LF = 2, CW = 13, SAT = 8191;
  logic clk = 1'b0, rst = 1'b1, de = 1'b0, hs = 1'b1, vs = 1'b1;
  logic [CW-1:0] ox, oy, htot, vtot, hact, vact;
  logic pv, sof, locked, err;
  video_timing_decoder #(
    .H_VA(HVA), .V_VA(VVA), .H_TOTAL(HT), .V_TOTAL(VT),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(LF), .CW(CW)
  ) dut (
    .iClk(clk), .iRst(rst), .iDE(de), .iHS(hs), .iVS(vs),
    .oX(ox), .oY(oy), .oPosValid(pv), .oSOF(sof),
    .oHTotal(htot), .oVTotal(vtot), .oHActive(hact), .oVActive(vact),
    .oLocked(locked), .oErr(err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0, err_seen = 0;
  typedef struct {int stamp; int x; int y; int sof;} pix_t;
  typedef struct {int stamp; int ht; int vt; int ha; int va; int lk; int er;} meas_t;
  pix_t pq[$];
  meas_t mq[$];
  bit seen_m, locked_m, sof_arm, line_de_m, rst_chk;
  int run_m, x_m, y_m, vlines, last_len, last_hact;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    seen_m = 0; locked_m = 0; sof_arm = 0; line_de_m = 0;
    run_m = 0; x_m = 0; y_m = 0; vlines = 0; last_len = 0; last_hact = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_pos"}, int'(ox | oy), 0);
    chk({tag, "_meas"}, int'(htot | vtot | hact | vact), 0);
    chk({tag, "_flags"}, int'({pv, sof, locked, err}), 0);
  endtask

  // a frame is judged only on its line/pixel counts and the last line's measurements
  task automatic vs_event();
    meas_t m;
    bit match;
    m.stamp = cyc + 2;
    if (!seen_m) begin
      m.ht = 0; m.vt = 0; m.ha = 0; m.va = 0; m.lk = 0; m.er = 0;
      seen_m = 1;
    end else begin
      match = last_len == HT && vlines == VT && last_hact == HVA && y_m == VVA;
      m.ht = last_len; m.vt = vlines; m.ha = last_hact; m.va = y_m;
      m.er = int'(locked_m && !match);
      run_m = match ? run_m + 1 : 0;
      locked_m = run_m >= LF;
      m.lk = int'(locked_m);
    end
    mq.push_back(m);
    vlines = 0;
    y_m = 0;
    sof_arm = 1;
  endtask

  task automatic hs_event(int len);
    vlines++;
    if (seen_m) last_len = len > SAT ? SAT : len;
    if (line_de_m) begin
      y_m++;
      line_de_m = 0;
    end
  endtask

  // lines of HT clocks, DE first, HS 4 clocks ending 4 before line end, VS over the last 2 lines
  task automatic drive_frame(int len17, int n_de, int de_w, int rl, int rp);
    for (int l = 0; l < VT; l++) begin
      int len;
      len = (l == 17) ? len17 : HT;
      for (int c = 0; c < len; c++) begin
        bit d, h, v, r;
        pix_t p;
        d = (l < n_de) && (c < de_w);
        h = (c >= len - 8) && (c < len - 4);
        v = l >= VT - 2;
        r = (l == rl) && (c == rp);
        @(negedge clk);
        if (rst_chk) begin
          chk_zero("midrst");
          rst_chk = 0;
        end
        rst = r; de = d; hs = ~h; vs = ~v;
        if (r) begin
          while (pq.size() != 0 && pq[$].stamp > cyc) void'(pq.pop_back());
          model_reset();
          rst_chk = 1;
        end else begin
          if (l == VT - 2 && c == 0) vs_event();
          if (d) begin
            p.stamp = cyc + 2; p.x = x_m; p.y = y_m; p.sof = int'(sof_arm);
            pq.push_back(p);
            sof_arm = 0;
            x_m++;
            line_de_m = 1;
          end
          if (l < n_de && c == de_w) begin
            if (seen_m) last_hact = x_m;
            x_m = 0;
          end
          if (c == len - 8) hs_event(len);
        end
      end
    end
  endtask

  task automatic random_frames(int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = $urandom_range(0, 5);
      if (k == 3) drive_frame($urandom_range(36, 44), VVA, HVA, -1, -1);
      else if (k == 4) drive_frame(HT, $urandom_range(0, 13), HVA, -1, -1);
      else if (k == 5) drive_frame(HT, VVA, $urandom_range(22, 26), -1, -1);
      else drive_frame(HT, VVA, HVA, -1, -1);
    end
  endtask

  always @(negedge clk) begin
    pix_t p;
    meas_t m;
    if (err) err_seen++;
    if (pv) begin
      if (pq.size() == 0) chk("pix_extra", 1, 0);
      else begin
        p = pq.pop_front();
        chk("pix_lat", cyc, p.stamp);
        chk("pix_x", int'(ox), p.x);
        chk("pix_y", int'(oy), p.y);
        chk("pix_sof", int'(sof), p.sof);
      end
    end
    while (pq.size() != 0 && pq[0].stamp < cyc) begin
      p = pq.pop_front();
      chk("pix_missing", 0, 1);
    end
    if (mq.size() != 0 && mq[0].stamp == cyc) begin
      m = mq.pop_front();
      chk("htotal", int'(htot), m.ht);
      chk("vtotal", int'(vtot), m.vt);
      chk("hactive", int'(hact), m.ha);
      chk("vactive", int'(vact), m.va);
      chk("locked", int'(locked), m.lk);
      chk("err_pulses", err_seen, m.er);
      err_seen = 0;
    end
  end

  initial begin
    model_reset();
    rst_chk = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (4) drive_frame(HT, VVA, HVA, -1, -1);
    drive_frame(HT - 1, VVA, HVA, -1, -1);
    repeat (2) drive_frame(HT, VVA, HVA, -1, -1);
    random_frames(10);
    repeat (3) drive_frame(HT, VVA, HVA, -1, -1);
    drive_frame(9000, VVA, HVA, -1, -1);
    repeat (3) drive_frame(HT, VVA, HVA, -1, -1);
    drive_frame(HT, VVA, HVA, 5, 10);
    repeat (3) drive_frame(HT, VVA, HVA, -1, -1);
    random_frames(8);
    drive_frame(HT, 0, HVA, -1, -1);
    repeat (2) drive_frame(HT, VVA, HVA, -1, -1);
    repeat (10) @(negedge clk);
    chk("pix_pending", pq.size(), 0);
    chk("meas_pending", mq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_timing_decoder.md
Name: video_timing_decoder

Overview:
- Receive-side counterpart of the raster timing generator: consumes a DE/HS/VS stream on the pixel clock and recovers the active-pixel position (x, y).
- Measures line/frame totals and active sizes, and reports lock against the expected mode.
- Sits at the input of capture/loopback paths and checks the display driver's output in self-test.

Parameters:
- H_VA, 640, expected active pixels per line
- V_VA, 480, expected active lines per frame
- H_TOTAL, 800, expected clocks per line (HS edge to HS edge)
- V_TOTAL, 525, expected lines per frame (VS edge to VS edge)
- SYNC_ACTIVE_LOW, 1, HS/VS asserted level is 0 when 1
- LOCK_FRAMES, 2, consecutive matching frames required for lock (1..15)
- CW, 13, width of all position/measurement counters

Ports:
- iClk  in  1  pixel clock
- iRst  in  1  reset, synchronous, active-high
- iDE  in  1  data enable
- iHS  in  1  horizontal sync, raw polarity
- iVS  in  1  vertical sync, raw polarity
- oX  out  CW  active pixel column, valid when oPosValid
- oY  out  CW  active line row, valid when oPosValid
- oPosValid  out  1  delayed DE aligned to oX/oY
- oSOF  out  1  one-cycle pulse with first active pixel of frame (x=0, y=0)
- oHTotal  out  CW  last measured clocks/line
- oVTotal  out  CW  last measured lines/frame
- oHActive  out  CW  last measured DE-high clocks/line
- oVActive  out  CW  last measured lines containing DE
- oLocked  out  1  timing matches parameters
- oErr  out  1  one-cycle pulse on any frame-level mismatch while LOCKED

Behaviour:
- Reset: all outputs 0; FSM SEARCH; internal counters 0; "seen VS" flag cleared.
- Pipeline: iDE/iHS/iVS registered once (stage 1), then normalised to active-high (stage 1 XOR polarity). Outputs are registered in stage 2. Latency from iDE to oPosValid with the matching oX/oY is exactly 2 cycles.
- Sync edges: the leading edge is the normalised 0->1 transition on stage-1 signals. Trailing edges are ignored.
- Horizontal:
  - hcnt increments every cycle.
  - On HS leading edge: oHTotal <= hcnt+1, hcnt <= 0.
  - x increments while DE is high. On DE falling edge: oHActive <= x, x <= 0, line_has_de set.
- Vertical:
  - On HS leading edge: vcnt++. If line_has_de, then y++ and line_has_de is cleared.
  - On VS leading edge: oVTotal <= vcnt, oVActive <= y, vcnt <= 0, y <= 0, frame check runs.
- Simultaneous HS and VS leading edges in the same cycle: HS update is applied first, then VS capture uses the post-increment vcnt.
- Saturation: every counter saturates at 2^CW-1 and never wraps. A saturated value fails the frame check.
- oSOF: asserted with the first oPosValid after a VS leading edge. It does not fire before the first VS edge after reset.
- Measurement outputs update only after the first VS edge after reset; the partial first frame is discarded.
- FSM states SEARCH, TRACK, LOCKED. A frame matches when all four measured values equal H_TOTAL, V_TOTAL, H_VA, V_VA.
  - SEARCH: on a VS edge with a match, go to TRACK with mcount=1. If LOCK_FRAMES=1, go directly to LOCKED instead.
  - TRACK: match -> mcount++; when mcount reaches LOCK_FRAMES -> LOCKED. Mismatch -> SEARCH, mcount=0.
  - LOCKED: mismatch -> SEARCH, oLocked <= 0, oErr pulse for 1 cycle.
- oLocked is high only in LOCKED. It is registered and changes the cycle after the VS-edge decision.
- No DE within a frame gives oVActive=0, which is a mismatch.
- iRst mid-frame returns everything to reset state next cycle. Re-lock needs 1 discarded partial frame plus LOCK_FRAMES frames.

Optional Feature:
- Macro VIDEO_TIMING_AUTOPOL_EN.
- Defined:
  - Per sync line, count clocks spent at raw 0 and at raw 1 over one HS period (HS) or one VS period (VS).
  - The shorter level is taken as the active level. Detected polarity is latched on each period end and replaces SYNC_ACTIVE_LOW.
  - A polarity change forces SEARCH without asserting oErr.
- Undefined: polarity fixed by SYNC_ACTIVE_LOW; no extra logic.

Decomposition:
- Shared package video_timing_pkg:
  - FSM state typedef (SEARCH/TRACK/LOCKED).
  - Standard 640x480@60 constants (active 640/480, totals 800/525, sync 96/2).
  - Default CW.
- One natural sub-module: sync_edge_detect. It registers the raw sync, applies polarity (and autopolarity counter when enabled), and emits a normalised level plus a leading-edge pulse. It is instantiated for HS and VS.

Test Plan:
- Nominal 640x480: drive a generator-conformant stream (800x525, HS 96 active-low, VS 2 lines). Required: oLocked rises after VS edge 3 (1 discarded + 2 matching); oHTotal=800, oVTotal=525, oHActive=640, oVActive=480; oX runs 0..639 with oPosValid exactly 2 cycles after iDE.
- Position/SOF: check the pixel at DE index 5 of active line 7. Required: oX=5, oY=7. oSOF fires once per frame, coincident with oX=0, oY=0.
- Mismatch while locked: shorten one line to 799 clocks. Required: next VS edge gives oErr 1-cycle pulse, oLocked->0, oHTotal=799. Re-lock after 2 clean frames.
- Reset mid-frame: assert iRst at line 200, pixel 300. Required: all outputs 0 next cycle; no oSOF until after the next VS edge; lock regained at the third VS edge.
- Saturation: hold HS inactive for 9000 clocks. Required: hcnt sticks at 8191; the frame check fails; no wrap to small values.
- Autopolarity (VIDEO_TIMING_AUTOPOL_EN): invert HS/VS polarity mid-run. Required: SEARCH entered without oErr; relock with identical measurements.
